crash_ctrl: RTL and testbench

Sequencing controller for the security-check datapath beside the branch unit. It collects crash requests from the variable-leak, load-consistency and overflow checkers and applies the enable and debug gating. It arms a redirect that forces the next resolved branch target to zero, then runs a timed clear of the check buffers. The branch unit consumes `redirect_o` in place of its inline crash condition. The bop buffer consumes `rst_buf_o` as its clear.

---
 rtl/crash_ctrl_if.sv | 27 ++
 rtl/crash_ctrl.sv | 63 ++++++
 tb/tb_crash_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/crash_ctrl_if.sv
// crash_ctrl_if: request, branch and status signals between the security checkers, branch unit and crash_ctrl
interface crash_ctrl_if #(parameter int VLEN = 32, parameter int CNT_W = 16);
   logic             en_crash_i;
   logic             debug_mode_i;
   logic             varleak_req_i;
   logic             loadcons_req_i;
   logic             ovf_req_i;
   logic             branch_valid_i;
   logic [VLEN-1:0]  pc_i;
   logic             crash_ack_i;
   logic             redirect_o;
   logic [1:0]       cause_o;
   logic [VLEN-1:0]  crash_pc_o;
   logic             rst_buf_o;
   logic             busy_o;
   logic [CNT_W-1:0] crash_count_o;
   modport master (
      output en_crash_i, debug_mode_i, varleak_req_i, loadcons_req_i, ovf_req_i,
             branch_valid_i, pc_i, crash_ack_i,
      input  redirect_o, cause_o, crash_pc_o, rst_buf_o, busy_o, crash_count_o
   );
   modport slave (
      input  en_crash_i, debug_mode_i, varleak_req_i, loadcons_req_i, ovf_req_i,
             branch_valid_i, pc_i, crash_ack_i,
      output redirect_o, cause_o, crash_pc_o, rst_buf_o, busy_o, crash_count_o
   );
endinterface

// File: rtl/crash_ctrl.sv
// crash_ctrl: gates checker crash requests, redirects the next branch to zero, then runs a timed buffer clear
module crash_ctrl #(
   parameter int VLEN       = 32,
   parameter int CLR_CYCLES = 4,
   parameter int CNT_W      = 16
) (
   input logic        clk_i,
   input logic        rst_i,
   crash_ctrl_if.slave bus
);
   localparam int CW = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, ARMED, CLEAR, HOLD} state_t;
   state_t           state, state_nx;
   logic [CW-1:0]    clr_cnt;
   logic [1:0]       cause, enc;
   logic [VLEN-1:0]  crash_pc;
   logic [CNT_W-1:0] count;
   logic             ok, req, redirect;
   assign ok  = bus.en_crash_i & ~bus.debug_mode_i;
   assign req = ok & (bus.varleak_req_i | bus.loadcons_req_i | bus.ovf_req_i);
   assign enc = bus.varleak_req_i ? 2'd1 : bus.loadcons_req_i ? 2'd2 : 2'd3;
   always_ff @(posedge clk_i)
      state <= rst_i ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = req ? (bus.branch_valid_i ? CLEAR : ARMED) : IDLE;
         ARMED:   state_nx = redirect ? CLEAR : !bus.en_crash_i ? IDLE : ARMED;
         CLEAR:   state_nx = clr_cnt == '0 ? HOLD : CLEAR;
         HOLD:    state_nx = bus.crash_ack_i ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      redirect      = bus.branch_valid_i & ok & (state == ARMED | (state == IDLE & req));
      bus.rst_buf_o = state == CLEAR;
      bus.busy_o    = state != IDLE;
   end
   // clear counter loads on the redirect so CLEAR lasts exactly CLR_CYCLES cycles
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cause    <= '0;
         crash_pc <= '0;
         count    <= '0;
         clr_cnt  <= '0;
      end else begin
         if (state == IDLE & req)
            cause <= enc;
         else if ((state == ARMED & !bus.en_crash_i) | (state == HOLD & bus.crash_ack_i))
            cause <= '0;
         if (redirect) begin
            crash_pc <= bus.pc_i;
            count    <= &count ? count : count + CNT_W'(1);
            clr_cnt  <= CW'(CLR_CYCLES - 1);
         end else if (state == CLEAR)
            clr_cnt <= clr_cnt - CW'(1);
      end
   end
   assign bus.redirect_o    = redirect;
   assign bus.cause_o       = cause;
   assign bus.crash_pc_o    = crash_pc;
   assign bus.crash_count_o = count;
endmodule

// File: tb/tb_crash_ctrl.sv
// tb_crash_ctrl: directed and random stimulus checked every cycle against a sequence-level model
module tb_crash_ctrl;
   localparam int CLR = 4;
   logic clk = 0, rst = 1;
   logic en = 0, dbg = 0, vl = 0, lc = 0, ov = 0, bv = 0, ack = 0;
   logic [31:0] pc = '0;
   int checks = 0, failures = 0;
   bit m_armed, m_hold;
   int m_clr, m_cause, m_cnt;
   logic [31:0] m_pc;
   crash_ctrl_if #(.VLEN(32), .CNT_W(16)) bus ();
   crash_ctrl_if #(.VLEN(32), .CNT_W(2))  bus_s ();
   crash_ctrl #(.VLEN(32), .CLR_CYCLES(CLR), .CNT_W(16)) dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
   crash_ctrl #(.VLEN(32), .CLR_CYCLES(CLR), .CNT_W(2))  dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s));
   assign {bus.en_crash_i, bus.debug_mode_i, bus.varleak_req_i, bus.loadcons_req_i, bus.ovf_req_i} = {en, dbg, vl, lc, ov};
   assign {bus.branch_valid_i, bus.pc_i, bus.crash_ack_i} = {bv, pc, ack};
   assign {bus_s.en_crash_i, bus_s.debug_mode_i, bus_s.varleak_req_i, bus_s.loadcons_req_i, bus_s.ovf_req_i} = {en, dbg, vl, lc, ov};
   assign {bus_s.branch_valid_i, bus_s.pc_i, bus_s.crash_ack_i} = {bv, pc, ack};
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic bit m_busy();
      return m_armed || m_clr > 0 || m_hold;
   endfunction
   function automatic bit m_redirect();
      return bv && en && !dbg && (m_armed || (!m_busy() && (vl || lc || ov)));
   endfunction
   task automatic compare();
      chk("redirect", bus.redirect_o, m_redirect());
      chk("cause", bus.cause_o, m_cause);
      chk("crash_pc", bus.crash_pc_o, m_pc);
      chk("rst_buf", bus.rst_buf_o, m_clr > 0);
      chk("busy", bus.busy_o, m_busy());
      chk("count", bus.crash_count_o, m_cnt > 65535 ? 65535 : m_cnt);
      chk("count_sat", bus_s.crash_count_o, m_cnt > 3 ? 3 : m_cnt);
      chk("redirect_s", bus_s.redirect_o, m_redirect());
   endtask
   // one crash: remember the PC, bump the count and schedule CLR cycles of buffer clear
   task automatic m_crash();
      m_pc = pc;
      m_cnt++;
      m_clr = CLR;
   endtask
   task automatic update();
      bit rd;
      rd = m_redirect();
      if (rst) begin
         {m_armed, m_hold} = '0;
         m_clr = 0; m_cause = 0; m_cnt = 0; m_pc = '0;
      end else if (!m_busy()) begin
         if (en && !dbg && (vl || lc || ov)) begin
            m_cause = vl ? 1 : lc ? 2 : 3;
            if (bv) m_crash(); else m_armed = 1;
         end
      end else if (m_armed) begin
         if (rd) begin m_armed = 0; m_crash(); end
         else if (!en) begin m_armed = 0; m_cause = 0; end
      end else if (m_clr > 0) begin
         m_clr--;
         if (m_clr == 0) m_hold = 1;
      end else if (ack) begin
         m_hold = 0; m_cause = 0;
      end
   endtask
   task automatic cyc();
      #1 compare();
      @(posedge clk);
      update();
      @(negedge clk);
      #1;
   endtask
   task automatic drain();
      repeat (4) cyc();
      ack = 1; cyc(); ack = 0;
   endtask
   initial begin
      @(posedge clk); update(); @(negedge clk); #1;
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_cause", bus.cause_o, 0);
      chk("rst_count", bus.crash_count_o, 0);
      chk("rst_redirect", bus.redirect_o, 0);
      rst = 0; en = 1;
      ov = 1; cyc();
      chk("basic_cause", bus.cause_o, 3);
      chk("basic_busy", bus.busy_o, 1);
      ov = 0; cyc(); cyc();
      bv = 1; pc = 32'h8000_0100; #1;
      chk("basic_redirect", bus.redirect_o, 1);
      cyc(); bv = 0;
      chk("basic_pc", bus.crash_pc_o, 32'h8000_0100);
      chk("basic_count", bus.crash_count_o, 1);
      chk("basic_rstbuf_first", bus.rst_buf_o, 1);
      repeat (3) cyc();
      chk("basic_rstbuf_last", bus.rst_buf_o, 1);
      cyc();
      chk("basic_rstbuf_off", bus.rst_buf_o, 0);
      chk("basic_hold_busy", bus.busy_o, 1);
      ack = 1; cyc(); ack = 0;
      chk("basic_ack_busy", bus.busy_o, 0);
      chk("basic_ack_cause", bus.cause_o, 0);
      {vl, lc, ov, bv} = 4'hf; pc = 32'h1234; #1;
      chk("prio_redirect", bus.redirect_o, 1);
      cyc(); {vl, lc, ov, bv} = '0;
      chk("prio_cause", bus.cause_o, 1);
      chk("prio_clear", bus.rst_buf_o, 1);
      drain();
      en = 0; ov = 1; cyc();
      chk("gate_en", bus.busy_o, 0);
      en = 1; dbg = 1; cyc();
      chk("gate_dbg", bus.busy_o, 0);
      dbg = 0; cyc(); ov = 0;
      dbg = 1; bv = 1; #1;
      chk("armed_dbg_redirect", bus.redirect_o, 0);
      cyc();
      chk("armed_dbg_stay", bus.busy_o, 1);
      {dbg, bv, en} = 3'b000; cyc();
      chk("armed_en_idle", bus.busy_o, 0);
      chk("armed_en_cause", bus.cause_o, 0);
      en = 1; lc = 1; bv = 1; cyc(); bv = 0;
      repeat (4) cyc();
      chk("mask_cause", bus.cause_o, 2);
      ack = 1; cyc(); ack = 0;
      chk("mask_ack_busy", bus.busy_o, 0);
      chk("mask_count", bus.crash_count_o, 3);
      cyc();
      chk("mask_recapture", bus.cause_o, 2);
      lc = 0; en = 0; cyc(); en = 1;
      ov = 1; bv = 1; cyc(); {ov, bv} = '0; cyc();
      rst = 1; cyc(); rst = 0;
      chk("midrst_rstbuf", bus.rst_buf_o, 0);
      chk("midrst_busy", bus.busy_o, 0);
      chk("midrst_pc", bus.crash_pc_o, 0);
      chk("midrst_count", bus.crash_count_o, 0);
      repeat (5) begin
         ov = 1; bv = 1; pc = $urandom; cyc(); {ov, bv} = '0;
         drain();
      end
      chk("sat_small", bus_s.crash_count_o, 3);
      chk("sat_big", bus.crash_count_o, 5);
      repeat (3000) begin
         rst = $urandom_range(0, 199) == 0;
         en  = $urandom_range(0, 9) != 0;
         dbg = $urandom_range(0, 9) == 0;
         vl  = $urandom_range(0, 5) == 0;
         lc  = $urandom_range(0, 5) == 0;
         ov  = $urandom_range(0, 5) == 0;
         bv  = $urandom_range(0, 2) == 0;
         ack = $urandom_range(0, 3) == 0;
         pc  = $urandom;
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
